// File: rtl/cpu_pkg.sv
// cpu_pkg: shared defaults and encodings for the fetch stage.
//   WIDTH, PC_STEP, RESET_PC : datapath/address defaults
//   S_IDLE..S_DRAIN          : fetch FSM state encodings
package cpu_pkg;

  localparam int              WIDTH    = 16;
  localparam int              PC_STEP  = 2;
  localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/pc_register.sv
// pc_register: program counter flop.
//   CLK, Reset  : clock, async active-high reset (loads RESET_PC)
//   load        : take load_val (has priority over inc)
//   load_val    : redirect target
//   inc         : advance by PC_STEP, wrapping modulo 2^WIDTH
//   pc          : current PC
module pc_register #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               PC_STEP  = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, fetches from imem and
// delivers each word to the IR with a one-cycle ir_w_flag pulse.
//   CLK, Reset                  : clock, async active-high reset
//   stall                       : downstream cannot take an instruction
//   redirect, redirect_pc       : branch/jump target (bit0 forced to 0)
//   imem_req/addr/ack/rdata     : instruction memory handshake
//   ir_w_flag, ir_data, pc_out  : registered delivery to the IR
//   fetch_count                 : delivered-instruction count; only built
//                                 when FETCH_COUNT_EN is defined, else 0
//
// state   | meaning
// S_IDLE  | one cycle after reset, no request
// S_REQ   | request to imem at pc
// S_HOLD  | word fetched but stalled; waiting to deliver it
// S_DRAIN | redirected while imem still owns the old request
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = cpu_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int               PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             ir_w_flag,
  output logic [WIDTH-1:0] ir_data,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] fetch_count
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic             ir_w_flag_q, ir_w_flag_d;
  logic [WIDTH-1:0] ir_data_q, ir_data_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;

  logic             pc_load;
  logic             pc_inc;
  logic [WIDTH-1:0] pc;

  pc_register #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (pc_load),
    .load_val (redirect_pc & ALIGN_MASK),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    drain_addr_d = drain_addr_q;
    ir_w_flag_d  = 1'b0;
    ir_data_d    = ir_data_q;
    pc_out_d     = pc_out_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        pc_load = redirect;
      end
      S_REQ: begin
        if (redirect) begin
          pc_load = 1'b1;
          // Without an ack the old request is still pending; remember its
          // address so imem_addr stays stable until imem completes it.
          if (!imem_ack) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc;
          end
        end else if (imem_ack) begin
          if (!stall) begin
            ir_w_flag_d = 1'b1;
            ir_data_d   = imem_rdata;
            pc_out_d    = pc;
            pc_inc      = 1'b1;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          state_d = S_REQ;
        end else if (!stall) begin
          ir_w_flag_d = 1'b1;
          ir_data_d   = hold_q;
          pc_out_d    = pc;
          pc_inc      = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_DRAIN: begin
        pc_load = redirect;
        // The ack retires the old request even if a new redirect arrives
        // in the same cycle; staying here would wait for an ack never sent.
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      drain_addr_q <= '0;
      ir_w_flag_q  <= 1'b0;
      ir_data_q    <= '0;
      pc_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      drain_addr_q <= drain_addr_d;
      ir_w_flag_q  <= ir_w_flag_d;
      ir_data_q    <= ir_data_d;
      pc_out_q     <= pc_out_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc;
  assign ir_w_flag = ir_w_flag_q;
  assign ir_data   = ir_data_q;
  assign pc_out    = pc_out_q;

`ifdef FETCH_COUNT_EN
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ir_w_flag_d) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule
